// File: rtl/bcd_serial_rx.sv
// ---------------------------------------------------------------------------
// bcd_serial_rx
// Deserialises a UART-style frame carrying one 6-bit BCD word (tens digit
// 0-3 in [5:4], units digit in [3:0]) and drives the downstream BCD
// converter through bcd_out / g_n. Flags framing, parity and BCD-range faults.
//
// Frame: start(0), d0..d5 LSB first, [even parity], stop(1).
// Optional feature macro: RX_PARITY_EN (adds the parity bit and parity_err).
//
// Ports
//   clk         in   1  clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   rx          in   1  serial line, idle high, asynchronous to clk
//   bcd_out     out  6  last accepted BCD word
//   g_n         out  1  converter enable, active low (0 = bcd_out valid)
//   word_valid  out  1  1-cycle pulse when bcd_out is updated
//   frame_err   out  1  1-cycle pulse: stop bit sampled 0
//   parity_err  out  1  1-cycle pulse: parity mismatch (0 without RX_PARITY_EN)
//   bcd_err     out  1  1-cycle pulse: accepted word has units digit > 9
// ---------------------------------------------------------------------------
module bcd_serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [5:0] bcd_out,
    output logic       g_n,
    output logic       word_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       bcd_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_meta;
    logic             rxs;
    logic [2:0]       state,      state_nxt;
    logic [CNT_W-1:0] cnt,        cnt_nxt;
    logic [2:0]       idx,        idx_nxt;
    logic [5:0]       shift,      shift_nxt;
    logic [5:0]       bcd_nxt;
    logic             g_n_nxt;
    logic             word_valid_nxt;
    logic             frame_err_nxt;
    logic             bcd_err_nxt;
`ifdef RX_PARITY_EN
    logic             par_bit,    par_bit_nxt;
    logic             parity_err_nxt;
`endif

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            bcd_out    <= '0;
            g_n        <= 1'b1;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            bcd_err    <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shift      <= shift_nxt;
            bcd_out    <= bcd_nxt;
            g_n        <= g_n_nxt;
            word_valid <= word_valid_nxt;
            frame_err  <= frame_err_nxt;
            bcd_err    <= bcd_err_nxt;
`ifdef RX_PARITY_EN
            par_bit    <= par_bit_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

`ifndef RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Next-state and output decode; all samples land mid-bit.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        idx_nxt        = idx;
        shift_nxt      = shift;
        bcd_nxt        = bcd_out;
        g_n_nxt        = g_n;
        word_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        bcd_err_nxt    = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_nxt    = par_bit;
        parity_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rxs) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    // LSB-first: after six shifts d0 sits in bit 0.
                    shift_nxt = {rxs, shift[5:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd5) begin
`ifdef RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = rxs;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!rxs) begin
                        frame_err_nxt = 1'b1;
                        g_n_nxt       = 1'b1;
                    end
`ifdef RX_PARITY_EN
                    // Even parity: data plus parity bit must hold an even count of ones.
                    else if (^{shift, par_bit}) begin
                        parity_err_nxt = 1'b1;
                        g_n_nxt        = 1'b1;
                    end
`endif
                    else begin
                        bcd_nxt        = shift;
                        g_n_nxt        = 1'b0;
                        word_valid_nxt = 1'b1;
                        bcd_err_nxt    = (shift[3:0] > 4'd9);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_serial_rx.sv
module tb_bcd_serial_rx;

    localparam int C = 16;
`ifdef RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Start-edge to outcome-pulse distance: sync + detect (3), half bit, then
    // (data + parity + stop) full bits to the mid-stop sample.
    localparam int LAT_NOM = 3 + C / 2 + (7 + PAR) * C;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [5:0] bcd_out;
    logic       g_n;
    logic       word_valid;
    logic       frame_err;
    logic       parity_err;
    logic       bcd_err;

    bcd_serial_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .bcd_out    (bcd_out),
        .g_n        (g_n),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic       fe;
        logic       pe;
        logic       be;
        logic [5:0] bcd;
        int         t0;
    } evt_t;

    evt_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         mon_en = 1'b0;
    logic [5:0] cur_bcd = 6'd0;
    logic       cur_gn  = 1'b1;
    logic [3:0] last_pulse = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame outcome from the receiver's rules, independent of how it is built.
    function automatic evt_t predict(input logic [5:0] w, input bit stop, input bit par_flip, input int t0);
        evt_t e;
        e.wv = 0; e.fe = 0; e.pe = 0; e.be = 0; e.bcd = w; e.t0 = t0;
        if (!stop)          e.fe = 1;
        else if (par_flip)  e.pe = 1;
        else begin
            e.wv = 1;
            e.be = (int'(w[3:0]) > 9);
        end
        return e;
    endfunction

    // Per-cycle compare of the DUT against the scoreboard and held-output model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (word_valid || frame_err || parity_err || bcd_err) begin
                last_pulse = {word_valid, frame_err, parity_err, bcd_err};
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 32'(last_pulse), 32'(0));
                end else begin
                    evt_t e;
                    int   d;
                    e = exp_q.pop_front();
                    d = cyc - e.t0;
                    check("pulses", 32'(last_pulse), 32'({e.wv, e.fe, e.pe, e.be}));
                    check("latency_window", 32'(d >= LAT_NOM - 2 && d <= LAT_NOM + 2), 32'(1));
                    if (e.wv) begin
                        cur_bcd = e.bcd;
                        cur_gn  = 1'b0;
                    end else begin
                        cur_gn  = 1'b1;
                    end
                end
            end
            check("bcd_out", 32'(bcd_out), 32'(cur_bcd));
            check("g_n", 32'(g_n), 32'(cur_gn));
        end
    end

    task automatic wait_c(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0] w, input bit stop, input bit par_flip);
        exp_q.push_back(predict(w, stop, par_flip, cyc));
        rx = 1'b0;
        wait_c(C);
        for (int i = 0; i < 6; i++) begin
            rx = w[i];
            wait_c(C);
        end
`ifdef RX_PARITY_EN
        rx = (^w) ^ par_flip;
        wait_c(C);
`endif
        rx = stop;
        wait_c(C);
        rx = 1'b1;
        check("frame_outcome_seen", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        // A low stop bit looks like a start edge; idle long enough for it to be rejected.
        if (!stop) wait_c(2 * C);
    endtask

    task automatic glitch();
        rx = 1'b0;
        wait_c(4);
        rx = 1'b1;
        wait_c(2 * C);
    endtask

    initial begin
        logic [5:0] w;
        bit         stop;
        bit         pf;

        reset_n = 1'b0;
        rx      = 1'b1;
        wait_c(4);
        check("rst_bcd_out", 32'(bcd_out), 32'(6'b000000));
        check("rst_g_n", 32'(g_n), 32'(1));
        check("rst_pulses", 32'({word_valid, frame_err, parity_err, bcd_err}), 32'(0));
        reset_n = 1'b1;
        wait_c(4);
        mon_en = 1'b1;

        // BCD 27
        send_frame(6'b100111, 1'b1, 1'b0);
        check("t27_bcd_out", 32'(bcd_out), 32'(6'b100111));
        check("t27_g_n", 32'(g_n), 32'(0));
        check("t27_pulses", 32'(last_pulse), 32'(4'b1000));
        wait_c(3);

        // Short low glitch while idle
        last_pulse = 4'b0000;
        glitch();
        check("glitch_bcd_out", 32'(bcd_out), 32'(6'b100111));
        check("glitch_g_n", 32'(g_n), 32'(0));
        check("glitch_no_pulse", 32'(last_pulse), 32'(0));

        // Good frame, then back-to-back frame with a bad stop bit
        send_frame(6'b010101, 1'b1, 1'b0);
        send_frame(6'b000011, 1'b0, 1'b0);
        check("ferr_pulses", 32'(last_pulse), 32'(4'b0100));
        check("ferr_bcd_out", 32'(bcd_out), 32'(6'b010101));
        check("ferr_g_n", 32'(g_n), 32'(1));

        // Units digit 12: forwarded with bcd_err
        send_frame(6'b001100, 1'b1, 1'b0);
        check("t12_pulses", 32'(last_pulse), 32'(4'b1001));
        check("t12_bcd_out", 32'(bcd_out), 32'(6'b001100));
        check("t12_g_n", 32'(g_n), 32'(0));

`ifdef RX_PARITY_EN
        send_frame(6'b100111, 1'b1, 1'b1);
        check("perr_pulses", 32'(last_pulse), 32'(4'b0010));
        check("perr_bcd_out", 32'(bcd_out), 32'(6'b001100));
        check("perr_g_n", 32'(g_n), 32'(1));
`endif

        // Reset during d3 of a frame
        w  = 6'b110110;
        rx = 1'b0;
        wait_c(C);
        for (int i = 0; i < 3; i++) begin
            rx = w[i];
            wait_c(C);
        end
        rx = w[3];
        wait_c(C / 2);
        reset_n = 1'b0;
        rx      = 1'b1;
        exp_q.delete();
        cur_bcd = 6'd0;
        cur_gn  = 1'b1;
        wait_c(5);
        check("midrst_bcd_out", 32'(bcd_out), 32'(6'b000000));
        check("midrst_g_n", 32'(g_n), 32'(1));
        check("midrst_pulses", 32'({word_valid, frame_err, parity_err, bcd_err}), 32'(0));
        reset_n = 1'b1;
        wait_c(2 * C);
        send_frame(6'b000101, 1'b1, 1'b0);
        check("postrst_bcd_out", 32'(bcd_out), 32'(6'b000101));
        check("postrst_g_n", 32'(g_n), 32'(0));

        // Randomised frames, gaps and glitches
        for (int n = 0; n < 60; n++) begin
            w    = 6'($urandom_range(0, 63));
            stop = ($urandom_range(0, 7) != 0);
`ifdef RX_PARITY_EN
            pf   = ($urandom_range(0, 5) == 0);
`else
            pf   = 1'b0;
`endif
            send_frame(w, stop, pf);
            if ($urandom_range(0, 9) == 0) glitch();
            else if ($urandom_range(0, 2) != 0) wait_c($urandom_range(1, 20));
        end

        wait_c(C);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
